// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i memory arbiter: FSM states, owner codes and
// default bus widths.
package rv32i_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_I    = 2'd1;
  localparam owner_t OWN_D    = 2'd2;

endpackage

// File: rtl/rv32i_arb_timer.sv
// Wait counter for one memory transaction; it stops counting once it reaches
// TIMEOUT and flags expired from then on.
module rv32i_arb_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  // Next count: clear wins over load, load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares the core's unified memory port between fetch and load/store: data has
// priority, a streak limit protects fetch, and a watchdog ends stuck accesses.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        owner
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [3:0]          m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic                d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                d_wins;
  logic                tmr_clear, tmr_load, tmr_en, tmr_expired;

  rv32i_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (TMR_W'(1)),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign d_wins = d_req && (!i_req || (streak_q < STREAK_W'(MAX_D_STREAK)));

  // Arbitration, handshake and response sequencing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = '0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_wins) begin
          state_d   = ST_ACCESS;
          owner_d   = OWN_D;
          streak_d  = i_req ? (streak_q + STREAK_W'(1)) : '0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          tmr_load  = 1'b1;
        end else if (i_req) begin
          state_d   = ST_ACCESS;
          owner_d   = OWN_I;
          streak_d  = '0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = 4'hF;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          tmr_load  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_ACCESS: begin
        tmr_en = 1'b1;
        // A completion in the same cycle as expiry still counts as success.
        if (m_ack || tmr_expired) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          if (owner_q == OWN_I) begin
            i_ack_d   = 1'b1;
            i_err_d   = !m_ack;
            i_rdata_d = m_ack ? m_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = !m_ack;
            d_rdata_d = m_ack ? m_rdata : '0;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        tmr_clear = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        m_req_d   = 1'b0;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'h0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign owner   = owner_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed scenarios plus a randomized
// transaction loop checked against a transaction-level arbitration model.
module tb_rv32i_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack, i_err;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;
  int model_streak = 0;

  rv32i_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Winner of an arbitration round: 0 none, 1 fetch, 2 data.
  function automatic int pick(input bit ip, input bit dp);
    if (dp && (!ip || model_streak < MAXS)) return 2;
    if (ip) return 1;
    return 0;
  endfunction

  function automatic void note_grant(input int g, input bit ip);
    if (g == 2) model_streak = ip ? model_streak + 1 : 0;
    else if (g == 1) model_streak = 0;
  endfunction

  task automatic test_reset();
    reset = 1'b0; i_req = 1'b1; i_addr = $urandom; d_req = 1'b1; d_we = 1'b1;
    d_be = 4'hF; d_addr = $urandom; d_wdata = $urandom; m_ack = 1'b1; m_rdata = $urandom;
    repeat (2) @(negedge clk);
    total++;
    if ({m_req, owner, i_ack, i_err, d_ack, d_err} !== 7'h0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {m_req, owner, i_ack, i_err, d_ack, d_err});
    end
    total++;
    if ({m_we, m_be, m_addr, m_wdata} !== 69'h0) begin
      bad++; $display("FAIL reset_mfields: got %h want 0", {m_we, m_be, m_addr, m_wdata});
    end
    total++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; m_rdata = '0; reset = 1'b1;
    model_streak = 0;
    @(negedge clk);
  endtask

  task automatic test_lone_fetch();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    note_grant(pick(1'b1, 1'b0), 1'b1);
    @(negedge clk);
    total++;
    if ({m_req, owner, m_we, m_be, m_addr} !== {1'b1, 2'd1, 1'b0, 4'hF, 32'h10}) begin
      bad++; $display("FAIL fetch_issue: got %h want %h", {m_req, owner, m_we, m_be, m_addr},
                      {1'b1, 2'd1, 1'b0, 4'hF, 32'h10});
    end
    m_ack = 1'b1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({i_ack, i_err, i_rdata, d_ack, m_req} !== {1'b1, 1'b0, 32'h13, 1'b0, 1'b0}) begin
      bad++; $display("FAIL fetch_resp: got %h want %h", {i_ack, i_err, i_rdata, d_ack, m_req},
                      {1'b1, 1'b0, 32'h13, 1'b0, 1'b0});
    end
    m_ack = 1'b0; i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({i_ack, d_ack, owner} !== 4'h0) begin
      bad++; $display("FAIL fetch_idle: got %b want 0", {i_ack, d_ack, owner});
    end
  endtask

  task automatic test_store_wait();
    int acks = 0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    note_grant(pick(1'b0, 1'b1), 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({m_req, owner, m_we, m_be, m_addr, m_wdata, d_ack} !==
          {1'b1, 2'd2, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
        bad++; $display("FAIL store_stable[%0d]: got %h", c,
                        {m_req, owner, m_we, m_be, m_addr, m_wdata, d_ack});
      end
      if (c == 3) begin m_ack = 1'b1; m_rdata = $urandom; end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if ({d_ack, d_err, i_ack, owner} !== {1'b1, 1'b0, 1'b0, 2'd2}) begin
          bad++; $display("FAIL store_resp: got %b want 10010", {d_ack, d_err, i_ack, owner});
        end
        m_ack = 1'b0; d_req = 1'b0;
      end
      if (d_ack === 1'b1) acks++;
    end
    total++;
    if (acks != 1) begin bad++; $display("FAIL store_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_starvation();
    int exp_q[$];
    int got_q[$];
    int n = 0;
    logic prev_mreq = 1'b0;
    int g;
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    d_addr = 32'h300; d_wdata = '0;
    for (int k = 0; k < 10; k++) begin
      g = pick(1'b1, 1'b1); note_grant(g, 1'b1); exp_q.push_back(g);
    end
    while (got_q.size() < 10 && n < 60) begin
      @(negedge clk); n++;
      m_ack = m_req; m_rdata = $urandom;
      if (m_req === 1'b1 && prev_mreq !== 1'b1) got_q.push_back(int'(owner));
      prev_mreq = m_req;
    end
    while (!(i_ack === 1'b1 || d_ack === 1'b1) && n < 80) begin
      @(negedge clk); n++; m_ack = m_req;
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    total++;
    if (got_q.size() != 10) begin
      bad++; $display("FAIL starve_count: got %0d grants want 10", got_q.size());
    end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] != exp_q[k]) begin
        bad++; $display("FAIL starve_order[%0d]: got owner %0d want %0d", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ack_n[$];
    logic prev_ack = 1'b0;
    i_req = 1'b1; i_addr = 32'h400;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      m_ack = m_req; m_rdata = $urandom;
      if (prev_ack) begin
        total++;
        if (owner !== 2'd0) begin bad++; $display("FAIL b2b_owner: got %0d want 0", owner); end
      end
      if (i_ack === 1'b1) begin ack_n.push_back(n); note_grant(1, 1'b1); end
      prev_ack = (i_ack === 1'b1);
    end
    i_req = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    total++;
    if (owner !== 2'd0) begin bad++; $display("FAIL b2b_owner_end: got %0d want 0", owner); end
    total++;
    if (ack_n.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", ack_n.size()); end
    for (int k = 1; k < ack_n.size(); k++) begin
      total++;
      if (ack_n[k] - ack_n[k-1] != 3) begin
        bad++; $display("FAIL b2b_spacing: got %0d want 3", ack_n[k] - ack_n[k-1]);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int late = 0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = $urandom & 32'hFFFF_FFFC;
    m_rdata = 32'hA5A5_5A5A; m_ack = 1'b0;
    note_grant(pick(1'b0, 1'b1), 1'b0);
    @(negedge clk);
    while (m_req === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
    total++;
    if (cnt != TMO) begin bad++; $display("FAIL timeout_len: got %0d want %0d", cnt, TMO); end
    total++;
    if ({d_ack, d_err, d_rdata, i_ack} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL timeout_resp: got %h want %h", {d_ack, d_err, d_rdata, i_ack},
                      {1'b1, 1'b1, 32'h0, 1'b0});
    end
    d_req = 1'b0; m_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) m_ack = 1'b0;
      if (i_ack === 1'b1 || d_ack === 1'b1 || m_req === 1'b1) late++;
    end
    total++;
    if (late != 0) begin bad++; $display("FAIL timeout_late_ack: got %0d events want 0", late); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
    @(negedge clk);
    total++;
    if (m_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got m_req %b want 1", m_req); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({m_req, owner, i_ack, i_err, d_ack, d_err} !== 7'h0) begin
      bad++; $display("FAIL rstmid_clear: got %b want 0", {m_req, owner, i_ack, i_err, d_ack, d_err});
    end
    reset = 1'b1; i_req = 1'b0; m_ack = 1'b1; m_rdata = $urandom;
    model_streak = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m_ack = 1'b0;
      if (i_ack === 1'b1 || d_ack === 1'b1 || m_req === 1'b1) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rstmid_stray: got %0d events want 0", stray); end
  endtask

  task automatic test_random();
    bit i_pend = 1'b0;
    bit d_pend = 1'b0;
    int g;
    int w;
    logic [71:0] exp_v;
    logic [DW-1:0] rd;
    for (int it = 0; it < 80; it++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend;
      g = pick(i_pend, d_pend); note_grant(g, i_pend);
      @(negedge clk);
      if (g == 0) begin
        total++;
        if ({m_req, owner} !== 3'b000) begin
          bad++; $display("FAIL rnd_idle[%0d]: got %b want 000", it, {m_req, owner});
        end
        continue;
      end
      exp_v = (g == 1) ? {1'b1, 2'd1, 1'b0, 4'hF, i_addr, 32'h0}
                       : {1'b1, 2'd2, d_we, d_be, d_addr, d_wdata};
      total++;
      if ({m_req, owner, m_we, m_be, m_addr, m_wdata} !== exp_v) begin
        bad++; $display("FAIL rnd_grant[%0d]: got %h want %h", it,
                        {m_req, owner, m_we, m_be, m_addr, m_wdata}, exp_v);
      end
      w = $urandom_range(0, 3);
      repeat (w) begin
        @(negedge clk);
        total++;
        if ({m_req, owner, m_we, m_be, m_addr, m_wdata} !== exp_v || i_ack !== 1'b0 || d_ack !== 1'b0) begin
          bad++; $display("FAIL rnd_wait[%0d]: got %h want %h", it,
                          {m_req, owner, m_we, m_be, m_addr, m_wdata}, exp_v);
        end
      end
      rd = $urandom; m_ack = 1'b1; m_rdata = rd;
      @(negedge clk);
      m_ack = 1'b0;
      total++;
      if (g == 1) begin
        if ({i_ack, i_err, i_rdata, d_ack, d_err} !== {1'b1, 1'b0, rd, 1'b0, 1'b0}) begin
          bad++; $display("FAIL rnd_iresp[%0d]: got %h want %h", it,
                          {i_ack, i_err, i_rdata, d_ack, d_err}, {1'b1, 1'b0, rd, 1'b0, 1'b0});
        end
        i_pend = 1'b0;
      end else begin
        if ({d_ack, d_err, d_rdata, i_ack, i_err} !== {1'b1, 1'b0, rd, 1'b0, 1'b0}) begin
          bad++; $display("FAIL rnd_dresp[%0d]: got %h want %h", it,
                          {d_ack, d_err, d_rdata, i_ack, i_err}, {1'b1, 1'b0, rd, 1'b0, 1'b0});
        end
        d_pend = 1'b0;
      end
      i_req = i_pend; d_req = d_pend;
      @(negedge clk);
      total++;
      if ({owner, m_req, i_ack, d_ack} !== 5'b0) begin
        bad++; $display("FAIL rnd_release[%0d]: got %b want 0", it, {owner, m_req, i_ack, d_ack});
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
    test_reset();
    test_lone_fetch();
    test_store_wait();
    test_starvation();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
